// File: rtl/float_round_pkg.sv
// Shared types and constant bit patterns for the float rounding pipeline.
package float_round_pkg;

  typedef enum logic [1:0] {RNE = 2'd0, RTZ = 2'd1, RUP = 2'd2, RDN = 2'd3} RoundMode;

  typedef enum logic [1:0] {FINITE = 2'd0, INF = 2'd1, NAN = 2'd2} FloatClass;

  // {exponent,fraction} patterns: NAN -> quiet NaN, INF -> infinity, FINITE -> max finite.
  function automatic logic [63:0] specialBits(FloatClass kind, int expW, int fracW);
    logic [63:0] expOnes;
    expOnes = ((64'd1 << expW) - 64'd1) << fracW;
    case (kind)
      NAN:     return expOnes | (64'd1 << (fracW - 1));
      INF:     return expOnes;
      default: return ((64'd1 << (expW + fracW)) - 64'd1) & ~(64'd1 << fracW);
    endcase
  endfunction

endpackage

// File: rtl/float_round_decide.sv
// Combinational rounding decision shared by the adder and multiplier rounders.
module float_round_decide
  import float_round_pkg::*;
#(
  parameter int TRAILING_BITS = 2
) (
  input  logic [1:0]               roundMode,
  input  logic                     sign,
  input  logic                     lsb,
  input  logic [TRAILING_BITS-1:0] trailingBits,
  input  logic                     stickyBit,
  output logic                     inexact,
  output logic                     roundUp,
  output logic                     nearUp
);

  logic guard;
  logic rest;

  assign guard = trailingBits[TRAILING_BITS-1];

  if (TRAILING_BITS > 1) begin : gRestWide
    assign rest = (|trailingBits[TRAILING_BITS-2:0]) | stickyBit;
  end else begin : gRestSticky
    assign rest = stickyBit;
  end

  assign inexact = guard | rest;

  // nearUp is the round-to-nearest-even increment regardless of the selected mode.
  assign nearUp = guard & (rest | lsb);

  always_comb begin
    roundUp = 1'b0;
    case (RoundMode'(roundMode))
      RNE:     roundUp = nearUp;
      RTZ:     roundUp = 1'b0;
      RUP:     roundUp = !sign & inexact;
      RDN:     roundUp = sign & inexact;
      default: roundUp = 1'b0;
    endcase
  end

endmodule

// File: rtl/float_round.sv
// Two-stage rounder: decides the increment in stage 1, applies it and resolves
// specials/overflow in stage 2, with a valid/ready handshake on both sides.
module float_round
  import float_round_pkg::*;
#(
  parameter int EXP           = 8,
  parameter int FRAC          = 23,
  parameter int TRAILING_BITS = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     inValid,
  output logic                     inReady,
  input  logic                     inSign,
  input  logic [EXP-1:0]           inExponent,
  input  logic [FRAC-1:0]          inFraction,
  input  logic [TRAILING_BITS-1:0] inTrailingBits,
  input  logic                     inStickyBit,
  input  logic                     inIsNan,
  input  logic [1:0]               roundMode,
  output logic                     outValid,
  input  logic                     outReady,
  output logic                     outSign,
  output logic [EXP-1:0]           outExponent,
  output logic [FRAC-1:0]          outFraction,
  output logic                     outInexact,
  output logic                     outOverflow
);

  localparam int W = EXP + FRAC;
  localparam logic [W-1:0] NAN_BITS = W'(specialBits(NAN, EXP, FRAC));
  localparam logic [W-1:0] INF_BITS = W'(specialBits(INF, EXP, FRAC));
  localparam logic [W-1:0] MAX_BITS = W'(specialBits(FINITE, EXP, FRAC));

  logic en;
  logic decInexact;
  logic decRoundUp;
  logic decNearUp;
  FloatClass inClass;

  logic          s1Valid;
  logic          s1Sign;
  logic [W-1:0]  s1Bits;
  FloatClass     s1Class;
  RoundMode      s1Mode;
  logic          s1RoundUp;
  logic          s1Inexact;
  logic          s1Overflow;

  logic          nextSign;
  logic [W-1:0]  nextBits;
  logic          nextInexact;
  logic          nextOverflow;

  assign en      = !outValid || outReady;
  assign inReady = en;

  float_round_decide #(.TRAILING_BITS(TRAILING_BITS)) decide (
    .roundMode    (roundMode),
    .sign         (inSign),
    .lsb          (inFraction[0]),
    .trailingBits (inTrailingBits),
    .stickyBit    (inStickyBit),
    .inexact      (decInexact),
    .roundUp      (decRoundUp),
    .nearUp       (decNearUp)
  );

  always_comb begin
    inClass = FINITE;
    if (inIsNan)
      inClass = NAN;
    else if (&inExponent)
      inClass = INF;
  end

  // Overflow is flagged when the max finite magnitude would be exceeded either in the
  // selected direction or by nearest rounding, so RTZ/directed modes still report it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1Valid    <= 1'b0;
      s1Sign     <= 1'b0;
      s1Bits     <= '0;
      s1Class    <= FINITE;
      s1Mode     <= RNE;
      s1RoundUp  <= 1'b0;
      s1Inexact  <= 1'b0;
      s1Overflow <= 1'b0;
    end else if (en) begin
      s1Valid    <= inValid;
      s1Sign     <= inSign;
      s1Bits     <= {inExponent, inFraction};
      s1Class    <= inClass;
      s1Mode     <= RoundMode'(roundMode);
      s1RoundUp  <= decRoundUp;
      s1Inexact  <= decInexact;
      s1Overflow <= ({inExponent, inFraction} == MAX_BITS) && (decRoundUp || decNearUp);
    end
  end

  always_comb begin
    nextSign     = s1Sign;
    nextBits     = s1Bits + W'(s1RoundUp);
    nextInexact  = s1Inexact;
    nextOverflow = 1'b0;
    case (s1Class)
      NAN: begin
        nextSign    = 1'b0;
        nextBits    = NAN_BITS;
        nextInexact = 1'b0;
      end
      INF: begin
        nextBits    = INF_BITS;
        nextInexact = 1'b0;
      end
      default: begin
        if (s1Overflow) begin
          nextOverflow = 1'b1;
          nextInexact  = 1'b1;
          case (s1Mode)
            RNE:     nextBits = INF_BITS;
            RTZ:     nextBits = MAX_BITS;
            RUP:     nextBits = s1Sign ? MAX_BITS : INF_BITS;
            default: nextBits = s1Sign ? INF_BITS : MAX_BITS;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      outValid    <= 1'b0;
      outSign     <= 1'b0;
      outExponent <= '0;
      outFraction <= '0;
      outInexact  <= 1'b0;
      outOverflow <= 1'b0;
    end else if (en) begin
      outValid    <= s1Valid;
      outSign     <= nextSign;
      outExponent <= nextBits[W-1:FRAC];
      outFraction <= nextBits[FRAC-1:0];
      outInexact  <= nextInexact;
      outOverflow <= nextOverflow;
    end
  end

endmodule
